// File: rtl/pr_bridge_timers.sv
// pr_bridge_timers -- device-side responder for the CPU peripheral bus.
//
// Decodes two 12-byte windows (timer0 at 0x7F00, timer1 at 0x7F10), each
// hosting a programmable down-counter with CTRL/PRESET/COUNT registers.
// Read data is combinational from PrAddr; interrupt lines go back to CP0.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   PrAddr   byte address from CPU (0 when access is outside device range)
//   PrWD     write data
//   PrWe     write strobe, qualified by PrAddr in the same cycle
//   PrRD     read data, combinational
//   HWInt    [2] timer0 IRQ, [3] timer1 IRQ, [7:4] external IRQs
//   ext_int  external interrupt inputs (only when PR_EXT_INT_EN is defined)
//
// Build option: define PR_EXT_INT_EN to add ext_int[3:0], synchronized by
// two flops onto HWInt[7:4]; otherwise HWInt[7:4] is tied low.

// One timer: register file plus IDLE/LOAD/CNT/INT down-counter FSM.
module pr_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,       // PrAddr falls inside this timer's window
    input  logic        we,
    input  logic [1:0]  reg_idx,   // 0 CTRL, 1 PRESET, 2 COUNT
    input  logic [31:0] wd,
    output logic [31:0] rd_data,   // 0 when not selected, so callers can OR
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_nxt;
    logic        en, im;
    logic [1:0]  mode;
    logic [31:0] preset, count, count_nxt;
    logic        irq_flag, flag_nxt, en_hw_clr;
    logic        wr_ctrl, wr_preset, auto_reload;

    assign wr_ctrl     = sel && we && (reg_idx == 2'd0);
    assign wr_preset   = sel && we && (reg_idx == 2'd1);
    assign auto_reload = (mode == 2'b01);   // 1x behaves as one-shot
    assign irq         = irq_flag & im;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        flag_nxt  = irq_flag;
        en_hw_clr = 1'b0;
        case (state)
            IDLE: if (en) state_nxt = LOAD;
            // LOAD completes even if EN was just cleared; CNT then pauses.
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: if (en) begin
                if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    // Flag rises on entry so it is visible during INT.
                    count_nxt = '0;
                    state_nxt = INT;
                    flag_nxt  = 1'b1;
                end
            end
            INT: if (auto_reload) begin
                flag_nxt  = 1'b0;       // single-cycle pulse in reload mode
                state_nxt = LOAD;
            end else begin
                en_hw_clr = 1'b1;       // one-shot: flag latches until bus write
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (wr_ctrl || wr_preset) flag_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            irq_flag <= 1'b0;
            preset   <= '0;
            en       <= 1'b0;
            mode     <= 2'b00;
            im       <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            irq_flag <= flag_nxt;
            // Bus write takes priority over the hardware EN clear.
            if (wr_ctrl)        {im, mode, en} <= wd[3:0];
            else if (en_hw_clr) en <= 1'b0;
            if (wr_preset)      preset <= wd;
        end
    end

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (reg_idx)
                2'd0:    rd_data = {28'd0, im, mode, en};
                2'd1:    rd_data = preset;
                2'd2:    rd_data = count;
                default: rd_data = '0;
            endcase
        end
    end
endmodule

module pr_bridge_timers (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWD,
    input  logic        PrWe,
`ifdef PR_EXT_INT_EN
    input  logic [3:0]  ext_int,
`endif
    output logic [31:0] PrRD,
    output logic [7:2]  HWInt
);
    localparam int NUM_TIMERS = 2;

    logic [NUM_TIMERS-1:0]       sel, irq, irq_q;
    logic [NUM_TIMERS-1:0][31:0] rd_data;
    logic [3:0]                  ext_q;

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_tmr
        localparam logic [31:0] BASE = 32'h7F00 + 32'(g * 16);
        assign sel[g] = (PrAddr >= BASE) && (PrAddr <= BASE + 32'hB);
        pr_timer u_tmr (
            .clk     (clk),
            .reset   (reset),
            .sel     (sel[g]),
            .we      (PrWe),
            .reg_idx (PrAddr[3:2]),
            .wd      (PrWD),
            .rd_data (rd_data[g]),
            .irq     (irq[g])
        );
    end

    // Unselected timers return 0, so an OR is the read mux.
    always_comb begin
        PrRD = '0;
        for (int i = 0; i < NUM_TIMERS; i++) PrRD = PrRD | rd_data[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_q <= '0;
        else        irq_q <= irq;
    end

`ifdef PR_EXT_INT_EN
    logic [3:0] ext_s1, ext_s2;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_s1 <= '0;
            ext_s2 <= '0;
        end else begin
            ext_s1 <= ext_int;
            ext_s2 <= ext_s1;
        end
    end
    assign ext_q = ext_s2;
`else
    assign ext_q = '0;
`endif

    assign HWInt = {ext_q, irq_q};
endmodule

// File: tb/tb_pr_bridge_timers.sv
// Self-checking bench for pr_bridge_timers: expected values are pushed to a
// scoreboard queue as stimulus is applied and popped as outputs are sampled
// on the falling clock edge.
module tb_pr_bridge_timers;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PrAddr = '0;
    logic [31:0] PrWD = '0;
    logic        PrWe = 1'b0;
    logic [31:0] PrRD;
    logic [7:2]  HWInt;
`ifdef PR_EXT_INT_EN
    logic [3:0]  ext_int = '0;
`endif

    pr_bridge_timers dut (
        .clk     (clk),
        .reset   (reset),
        .PrAddr  (PrAddr),
        .PrWD    (PrWD),
        .PrWe    (PrWe),
`ifdef PR_EXT_INT_EN
        .ext_int (ext_int),
`endif
        .PrRD    (PrRD),
        .HWInt   (HWInt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t s;
        s.tag = tag;
        s.exp = exp;
        sb.push_back(s);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_t s;
        if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            s = sb.pop_front();
            check(s.tag, obs, s.exp);
        end
    endtask

    // Caller sits on a falling edge; write is captured at the next rising edge.
    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        PrAddr = addr;
        PrWD   = data;
        PrWe   = 1'b1;
        @(negedge clk);
        PrWe   = 1'b0;
        PrAddr = '0;
        PrWD   = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        PrAddr = addr;
        sb_push(tag, exp);
        #1;
        sb_pop(PrRD);
    endtask

    task automatic hw_chk(input string tag, input logic [5:0] exp);
        sb_push(tag, 32'(exp));
        #1;
        sb_pop(32'(HWInt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        PrWe   = 1'b0;
        PrAddr = '0;
        reset  = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] n;
        logic [31:0] e;

        // Reset state while reset is held low.
        #1;
        rd("rst_ctrl0", 32'h7F00, 32'h0);
        rd("rst_preset1", 32'h7F14, 32'h0);
        hw_chk("rst_hwint", 6'h00);
        do_reset();

        // One-shot, PRESET=5, IM=1.
        bus_wr(32'h7F04, 32'd5);
        bus_wr(32'h7F00, 32'h9);
        step(); step();
        for (int k = 0; k < 10; k++) begin
            sb_push($sformatf("os_count_k%0d", k), (k <= 5) ? 32'(5 - k) : 32'd0);
            sb_push($sformatf("os_hw2_k%0d", k), (k + 2 >= 8) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 10; k++) begin
            PrAddr = 32'h7F08;
            #1;
            sb_pop(PrRD);
            sb_pop(32'(HWInt[2]));
            step();
        end
        rd("os_ctrl_en_cleared", 32'h7F00, 32'h8);
        bus_wr(32'h7F04, 32'd5);
        step();
        hw_chk("os_irq_cleared", 6'h00);

        // Minimum-latency cases: PRESET = 0, 1, 2.
        for (int p = 0; p < 3; p++) begin
            do_reset();
            n = 32'(p);
            bus_wr(32'h7F04, n);
            bus_wr(32'h7F00, 32'h9);
            for (int k = 1; k <= 8; k++) begin
                step();
                e = (k >= ((p < 2) ? 1 : p) + 3) ? 32'd1 : 32'd0;
                sb_push($sformatf("minlat_p%0d_k%0d", p, k), e);
                #1;
                sb_pop(32'(HWInt[2]));
            end
        end

        // Timer1 auto-reload, PRESET=3, IM=1: pulse every 5 cycles.
        do_reset();
        bus_wr(32'h7F14, 32'd3);
        bus_wr(32'h7F10, 32'hB);
        for (int k = 1; k <= 17; k++) begin
            step();
            sb_push($sformatf("ar_hw3_k%0d", k),
                    (k >= 6 && (k - 6) % 5 == 0) ? 32'd1 : 32'd0);
            sb_push($sformatf("ar_t0_hw2_k%0d", k), 32'd0);
            sb_push($sformatf("ar_t0_count_k%0d", k), 32'd0);
            PrAddr = 32'h7F08;
            #1;
            sb_pop(32'(HWInt[3]));
            sb_pop(32'(HWInt[2]));
            sb_pop(PrRD);
        end

        // Auto-reload with IM=0: no interrupt, counter still reloads.
        do_reset();
        bus_wr(32'h7F14, 32'd3);
        bus_wr(32'h7F10, 32'h3);
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k < 2) e = 32'd0;
            else e = (((k - 2) % 5) < 3) ? 32'(3 - (k - 2) % 5) : 32'd0;
            sb_push($sformatf("nim_count_k%0d", k), e);
            sb_push($sformatf("nim_hw3_k%0d", k), 32'd0);
            PrAddr = 32'h7F18;
            #1;
            sb_pop(PrRD);
            sb_pop(32'(HWInt[3]));
        end

        // Pause and resume via EN.
        do_reset();
        bus_wr(32'h7F14, 32'd10);
        bus_wr(32'h7F10, 32'h3);
        step(); step();
        rd("pause_start", 32'h7F18, 32'd10);
        step(); step();
        rd("pause_pre", 32'h7F18, 32'd8);
        bus_wr(32'h7F10, 32'h2);
        rd("pause_ctrl", 32'h7F10, 32'h2);
        rd("pause_edge", 32'h7F18, 32'd7);
        for (int k = 0; k < 3; k++) begin
            step();
            rd($sformatf("pause_hold_k%0d", k), 32'h7F18, 32'd7);
        end
        bus_wr(32'h7F10, 32'h3);
        rd("resume_edge", 32'h7F18, 32'd7);
        step();
        rd("resume_1", 32'h7F18, 32'd6);
        step();
        rd("resume_2", 32'h7F18, 32'd5);

        // Unmapped addresses and ignored bits/registers.
        rd("unmapped_7f0c", 32'h7F0C, 32'h0);
        rd("unmapped_7f1c", 32'h7F1C, 32'h0);
        rd("unmapped_7f20", 32'h7F20, 32'h0);
        rd("unmapped_0", 32'h0, 32'h0);
        step();
        bus_wr(32'h7F04, 32'h10);
        bus_wr(32'h7F08, 32'hFFFF_FFFF);
        rd("count_ro", 32'h7F08, 32'h0);
        bus_wr(32'h7F00, 32'hFFFF_FFFF);
        rd("ctrl_mask", 32'h7F00, 32'hF);
        rd("preset_rb", 32'h7F04, 32'h10);

        // Asynchronous reset mid-operation with a pending IRQ.
        do_reset();
        bus_wr(32'h7F14, 32'd1);
        bus_wr(32'h7F10, 32'h9);
        bus_wr(32'h7F04, 32'h10);
        bus_wr(32'h7F00, 32'h9);
        step(); step(); step(); step();
        hw_chk("pre_rst_hwint", 6'h02);
        rd("pre_rst_count0", 32'h7F08, 32'd14);
        #1;
        reset = 1'b0;
        rd("arst_count0", 32'h7F08, 32'h0);
        hw_chk("arst_hwint", 6'h00);
        rd("arst_ctrl0", 32'h7F00, 32'h0);
        rd("arst_preset0", 32'h7F04, 32'h0);
        rd("arst_ctrl1", 32'h7F10, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(); step(); step();
        rd("post_rst_count0", 32'h7F08, 32'h0);
        rd("post_rst_ctrl1", 32'h7F10, 32'h0);
        hw_chk("post_rst_hwint", 6'h00);

`ifdef PR_EXT_INT_EN
        ext_int = 4'b1010;
        step();
        sb_push("ext_1edge", 32'h0);
        #1;
        sb_pop(32'(HWInt[7:4]));
        step();
        sb_push("ext_2edge", 32'hA);
        #1;
        sb_pop(32'(HWInt[7:4]));
`else
        for (int k = 0; k < 3; k++) begin
            step();
            sb_push($sformatf("ext_tied_k%0d", k), 32'h0);
            #1;
            sb_pop(32'(HWInt[7:4]));
        end
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pr_bridge_timers.md
# pr_bridge_timers

Device-side responder for the CPU's peripheral bus (PrAddr/PrWD/PrWe/PrRD): decodes the two 12-byte device windows at 0x7F00 and 0x7F10, hosts one programmable down-counter timer in each, returns read data combinationally, and drives the HWInt lines back into CP0. Sits at the top level beside `cpu`, closing the loop between its bus outputs and its `HWInt`/`PrRD` inputs.

## Interface
- No parameters.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- PrAddr  in  32  byte address from CPU; 0 when CPU access is out of device range.
- PrWD  in  32  write data.
- PrWe  in  1  write strobe, valid with PrAddr in same cycle.
- PrRD  out  32  read data, combinational from PrAddr.
- HWInt  out  6  [7:2]; bit 2 = timer0 IRQ, bit 3 = timer1 IRQ, bits 7:4 per Configuration.

## Operation
- Decode: timer0 when 0x7F00 ≤ PrAddr ≤ 0x7F0B, timer1 when 0x7F10 ≤ PrAddr ≤ 0x7F1B; register = PrAddr[3:2]: 0 CTRL, 1 PRESET, 2 COUNT. Any other address: read 0, write ignored.
- CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM; bits [31:4] read 0, write ignored.
- PRESET: 32-bit R/W. COUNT: read-only, writes ignored.
- Per-timer FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 → LOAD.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT: EN=0 → hold COUNT, stay CNT (pause). EN=1 and COUNT > 1 → COUNT−1. EN=1 and COUNT ≤ 1 → COUNT ← 0, → INT.
  - INT: set irq_flag. MODE 00: EN ← 0, → IDLE; irq_flag stays set. MODE 01: irq_flag set for this cycle only, → LOAD.
- irq_flag clears on any write to that timer's CTRL or PRESET.
- Timer IRQ = irq_flag & IM; HWInt bit registered (one cycle after irq_flag).
- PRESET written mid-count: used at next LOAD only; current COUNT unaffected.
- Same-cycle bus write and hardware update of CTRL.EN: bus write wins.
- EN cleared by bus in LOAD: LOAD still completes, then pauses in CNT.
- PRESET = 0 or 1: LOAD → CNT → INT, IRQ after minimum latency.

## Timing
- Reset (asserted low, async): CTRL, PRESET, COUNT, irq_flag = 0; FSMs IDLE; HWInt = 0; PrRD = 0 (follows address decode of zeroed registers).
- Reads: zero latency; PrRD valid in same cycle as PrAddr; reflects register values before the edge.
- Writes: captured at rising edge with PrWe=1; readable next cycle.
- EN write at edge t: LOAD at t+1, COUNT = PRESET readable after t+2 edge; with PRESET = N ≥ 2, INT reached N cycles after entering CNT; HWInt bit high one cycle after INT.
- Auto-reload period = N + 2 cycles; HWInt pulse width 1 cycle (if IM=1).
- Reset release mid-count: registers return to reset values immediately; no pending IRQ survives.

## Configuration
- PR_EXT_INT_EN defined: adds input `ext_int [3:0]`; each bit passes a 2-flop synchronizer (reset 0) and drives HWInt[7:4], 2-cycle latency, level passthrough.
- Not defined: no `ext_int` port; HWInt[7:4] tied 0.

## Test plan
- Reset low mid-operation with PRESET=0x10 counting → all registers read 0, HWInt = 6'b0 while reset low and after release.
- Write PRESET(0x7F04)=5, CTRL(0x7F00)=0x9 (EN, mode 0, IM) → COUNT reads 5,4,3,2,1,0; HWInt[2]=1 and holds; CTRL reads 0x8; write PRESET=5 → HWInt[2]=0 next cycle.
- Timer1 PRESET(0x7F14)=3, CTRL(0x7F10)=0xB (auto-reload) → HWInt[3] one-cycle pulse every 5 cycles; timer0 unaffected.
- Same setup with IM=0 → HWInt[3] stays 0, FSM still reloads; clear EN mid-count → COUNT frozen, resumes on EN=1.
- Read 0x7F0C, 0x7F20, 0x0 → PrRD=0; write 0xFFFFFFFF to COUNT 0x7F08 and CTRL 0x7F00 → COUNT unchanged, CTRL reads 0xF.
- With PR_EXT_INT_EN: ext_int=4'b1010 → HWInt[7:4]=4'b1010 after 2 edges; without macro → HWInt[7:4]=0.
